// File: rtl/vscale_mul_div_iter_pkg.sv
// Shared constants for the vscale iterative multiply/divide unit:
// operation codes, output select codes and FSM state encodings.
package vscale_mul_div_iter_pkg;

    localparam int MD_OP_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic MD_OUT_LO = 1'b0;
    localparam logic MD_OUT_HI = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_COMPUTE = 3'd2,
        S_FINISH  = 3'd3,
        S_DONE    = 3'd4
    } md_state_t;

endpackage

// File: rtl/vscale_mul_div_iter_if.sv
// Request/response handshake bundle between the execute-stage control
// (master) and the multiply/divide unit (slave).
interface vscale_mul_div_iter_if
    import vscale_mul_div_iter_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic [MD_OP_WIDTH-1:0] req_op;
    logic                   req_in_1_signed;
    logic                   req_in_2_signed;
    logic                   req_out_sel;
    logic [XLEN-1:0]        req_in_1;
    logic [XLEN-1:0]        req_in_2;
    logic                   kill;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [XLEN-1:0]        resp_out;

    modport master (
        output req_valid, req_op, req_in_1_signed, req_in_2_signed,
               req_out_sel, req_in_1, req_in_2, kill, resp_ready,
        input  req_ready, resp_valid, resp_out
    );

    modport slave (
        input  req_valid, req_op, req_in_1_signed, req_in_2_signed,
               req_out_sel, req_in_1, req_in_2, kill, resp_ready,
        output req_ready, resp_valid, resp_out
    );

endinterface

// File: rtl/vscale_md_negate.sv
// Conditional two's-complement negator: out = en ? -in : in.
module vscale_md_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    assign out = en ? (~in + {{(WIDTH-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/vscale_mul_div_iter.sv
// Iterative radix-2 multiply/divide unit (RV32M/RV64M). Operands are
// reduced to unsigned magnitudes, processed one bit per cycle (shift-add
// multiply or restoring divide) and the sign is restored at the end.
module vscale_mul_div_iter
    import vscale_mul_div_iter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vscale_mul_div_iter_if.slave md
);

    md_state_t              state, state_nxt;
    logic [CNT_W-1:0]       counter;
    logic [MD_OP_WIDTH-1:0] op;
    logic                   out_sel;
    logic                   in_1_signed;
    logic                   in_2_signed;
    logic                   neg_out;
    // a: multiplicand / dividend, then quotient as it shifts in.
    // b: multiplier (shifted right) / divisor.
    logic [XLEN-1:0]        a, b;
    logic [XLEN:0]          rem;
    logic [2*XLEN-1:0]      acc;
    logic [XLEN-1:0]        resp_out_r;

    logic                   accept;
    logic                   is_mul;
    logic                   sign_1, sign_2;
    logic [XLEN-1:0]        a_abs, b_abs;
    logic [XLEN:0]          mul_sum;
    logic [XLEN:0]          div_shift;
    logic [XLEN+1:0]        div_diff;
    logic                   div_ok;
    logic [2*XLEN-1:0]      res_raw, res_neg;
    logic [XLEN-1:0]        res_sel;

    assign md.req_ready  = (state == S_IDLE) && !md.kill;
    assign md.resp_valid = (state == S_DONE);
    assign md.resp_out   = resp_out_r;

    assign accept = md.req_valid && md.req_ready;
    // Reserved op code 3 falls through to multiply.
    assign is_mul = (op != MD_OP_DIV) && (op != MD_OP_REM);
    assign sign_1 = in_1_signed && a[XLEN-1];
    assign sign_2 = in_2_signed && b[XLEN-1];

    vscale_md_negate #(.WIDTH(XLEN)) u_neg_in_1 (
        .in  (a),
        .en  (sign_1),
        .out (a_abs)
    );

    vscale_md_negate #(.WIDTH(XLEN)) u_neg_in_2 (
        .in  (b),
        .en  (sign_2),
        .out (b_abs)
    );

    // Shift-add step: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the accumulator right.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b[0] ? a : {XLEN{1'b0}})};

    // Restoring step: bring in the next dividend bit and trial-subtract
    // the divisor; a borrow means the quotient bit is 0 and no restore.
    assign div_shift = {rem[XLEN-1:0], a[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b};
    assign div_ok    = !div_diff[XLEN+1];

    always_comb begin
        res_raw = acc;
        if (op == MD_OP_DIV) begin
            res_raw = {{XLEN{1'b0}}, a};
        end else if (op == MD_OP_REM) begin
            res_raw = {{(XLEN-1){1'b0}}, rem};
        end
    end

    vscale_md_negate #(.WIDTH(2*XLEN)) u_neg_res (
        .in  (res_raw),
        .en  (neg_out),
        .out (res_neg)
    );

    assign res_sel = (is_mul && out_sel == MD_OUT_HI) ? res_neg[2*XLEN-1:XLEN]
                                                      : res_neg[XLEN-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_SETUP;
            S_SETUP:   state_nxt = S_COMPUTE;
            S_COMPUTE: if (counter == CNT_W'(1)) state_nxt = S_FINISH;
            S_FINISH:  state_nxt = S_DONE;
            S_DONE:    if (md.resp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (md.kill) begin
            state_nxt = S_IDLE;
        end
    end

    // Operand capture, magnitude setup, per-bit iteration and result register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= '0;
            op          <= MD_OP_MUL;
            out_sel     <= MD_OUT_LO;
            in_1_signed <= 1'b0;
            in_2_signed <= 1'b0;
            neg_out     <= 1'b0;
            a           <= '0;
            b           <= '0;
            rem         <= '0;
            acc         <= '0;
            resp_out_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op          <= md.req_op;
                        out_sel     <= md.req_out_sel;
                        in_1_signed <= md.req_in_1_signed;
                        in_2_signed <= md.req_in_2_signed;
                        a           <= md.req_in_1;
                        b           <= md.req_in_2;
                    end
                end
                S_SETUP: begin
                    a       <= a_abs;
                    b       <= b_abs;
                    counter <= CNT_W'(XLEN);
                    acc     <= '0;
                    rem     <= '0;
                    if (op == MD_OP_REM) begin
                        neg_out <= sign_1;
                    end else if (op == MD_OP_DIV) begin
                        // Divide by zero must yield all ones, so no sign fix-up.
                        neg_out <= (sign_1 ^ sign_2) && (b != '0);
                    end else begin
                        neg_out <= sign_1 ^ sign_2;
                    end
                end
                S_COMPUTE: begin
                    counter <= counter - CNT_W'(1);
                    if (is_mul) begin
                        acc <= {mul_sum, acc[XLEN-1:1]};
                        b   <= {1'b0, b[XLEN-1:1]};
                    end else begin
                        rem <= div_ok ? div_diff[XLEN:0] : div_shift;
                        a   <= {a[XLEN-2:0], div_ok};
                    end
                end
                S_FINISH: begin
                    if (!md.kill) begin
                        resp_out_r <= res_sel;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_mul_div_iter.sv
// Scoreboard bench for vscale_mul_div_iter at XLEN=32 and XLEN=64.
module tb_vscale_mul_div_iter;
    import vscale_mul_div_iter_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    vscale_mul_div_iter_if #(.XLEN(32)) m32 ();
    vscale_mul_div_iter_if #(.XLEN(64)) m64 ();

    vscale_mul_div_iter #(.XLEN(32)) dut32 (.clk(clk), .reset_n(reset_n), .md(m32));
    vscale_mul_div_iter #(.XLEN(64)) dut64 (.clk(clk), .reset_n(reset_n), .md(m64));

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
        string       tag;
    } sb_t;

    sb_t q32[$];
    sb_t q64[$];
    sb_t e32, e64;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  rv32_prev = 1'b0;
    bit  rv64_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model in 128-bit signed arithmetic.
    function automatic logic [63:0] md_model(input int xlen, input logic [1:0] op,
                                             input bit s1, input bit s2, input bit sel,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0]        mask, ae, be, p;
        logic signed [127:0] sa, sb, r;
        mask = (xlen == 64) ? {64'd0, {64{1'b1}}} : {96'd0, {32{1'b1}}};
        ae = {64'd0, a} & mask;
        be = {64'd0, b} & mask;
        if (s1 && ae[xlen-1]) ae = ae | ~mask;
        if (s2 && be[xlen-1]) be = be | ~mask;
        if (op == MD_OP_DIV || op == MD_OP_REM) begin
            if ((be & mask) == 128'd0)
                return (op == MD_OP_DIV) ? mask[63:0] : (ae[63:0] & mask[63:0]);
            sa = $signed(ae);
            sb = $signed(be);
            r  = (op == MD_OP_DIV) ? (sa / sb) : (sa % sb);
            return r[63:0] & mask[63:0];
        end
        p = ae * be;
        if (sel) p = p >> xlen;
        return p[63:0] & mask[63:0];
    endfunction

    task automatic issue(input bit w64, input logic [1:0] op, input bit s1, input bit s2,
                         input bit sel, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input string tag);
        sb_t e;
        int  g = 0;
        @(negedge clk);
        if (w64) begin
            m64.req_valid = 1'b1; m64.req_op = op; m64.req_in_1_signed = s1;
            m64.req_in_2_signed = s2; m64.req_out_sel = sel; m64.req_in_1 = a; m64.req_in_2 = b;
        end else begin
            m32.req_valid = 1'b1; m32.req_op = op; m32.req_in_1_signed = s1;
            m32.req_in_2_signed = s2; m32.req_out_sel = sel; m32.req_in_1 = a[31:0]; m32.req_in_2 = b[31:0];
        end
        while (!(w64 ? m64.req_ready : m32.req_ready) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            check_val({tag, " accept"}, 64'(w64 ? m64.req_ready : m32.req_ready), 64'd1);
            m32.req_valid = 1'b0;
            m64.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.exp     = md_model(w64 ? 64 : 32, op, s1, s2, sel, a, b);
        e.acc_cyc = cyc;
        e.tag     = tag;
        // Inputs are don't-care after the accept edge; scramble them.
        if (w64) begin
            m64.req_valid = 1'b0; m64.req_in_1 = ~a; m64.req_in_2 = ~b; m64.req_op = ~op;
        end else begin
            m32.req_valid = 1'b0; m32.req_in_1 = ~a[31:0]; m32.req_in_2 = ~b[31:0]; m32.req_op = ~op;
        end
        if (push) begin
            if (w64) q64.push_back(e);
            else     q32.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q32.size() != 0 || q64.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) check_val("drain", 64'(q32.size() + q64.size()), 64'd0);
        @(negedge clk);
    endtask

    // Response monitor, XLEN=32: latency on rise, value on handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m32.resp_valid && !rv32_prev && q32.size() > 0)
                check_val({q32[0].tag, " latency"}, 64'(cyc - q32[0].acc_cyc), 64'd34);
            if (m32.resp_valid && m32.resp_ready) begin
                if (q32.size() == 0) begin
                    check_val("resp32 unexpected", 64'(m32.resp_valid), 64'd0);
                end else begin
                    e32 = q32.pop_front();
                    check_val(e32.tag, 64'(m32.resp_out), e32.exp);
                end
            end
        end
        rv32_prev = m32.resp_valid;
    end

    // Response monitor, XLEN=64.
    always @(negedge clk) begin
        if (reset_n) begin
            if (m64.resp_valid && !rv64_prev && q64.size() > 0)
                check_val({q64[0].tag, " latency"}, 64'(cyc - q64[0].acc_cyc), 64'd66);
            if (m64.resp_valid && m64.resp_ready) begin
                if (q64.size() == 0) begin
                    check_val("resp64 unexpected", 64'(m64.resp_valid), 64'd0);
                end else begin
                    e64 = q64.pop_front();
                    check_val(e64.tag, m64.resp_out, e64.exp);
                end
            end
        end
        rv64_prev = m64.resp_valid;
    end

    function automatic logic [63:0] pick64(input int k);
        case (k)
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return {64{1'b1}};
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] cop [8];
        bit         cs1 [8];
        bit         cs2 [8];
        bit         csel[8];
        bit         seen;
        int         g;

        cop  = '{MD_OP_MUL, MD_OP_MUL, MD_OP_MUL, MD_OP_MUL, MD_OP_DIV, MD_OP_DIV, MD_OP_REM, MD_OP_REM};
        cs1  = '{1, 1, 1, 0, 1, 0, 1, 0};
        cs2  = '{1, 1, 0, 0, 1, 0, 1, 0};
        csel = '{0, 1, 1, 1, 0, 0, 0, 0};

        reset_n = 1'b0;
        m32.req_valid = 1'b0; m32.req_op = '0; m32.req_in_1_signed = 1'b0; m32.req_in_2_signed = 1'b0;
        m32.req_out_sel = 1'b0; m32.req_in_1 = '0; m32.req_in_2 = '0; m32.kill = 1'b0; m32.resp_ready = 1'b1;
        m64.req_valid = 1'b0; m64.req_op = '0; m64.req_in_1_signed = 1'b0; m64.req_in_2_signed = 1'b0;
        m64.req_out_sel = 1'b0; m64.req_in_1 = '0; m64.req_in_2 = '0; m64.kill = 1'b0; m64.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst req_ready",  64'(m32.req_ready),  64'd1);
        check_val("rst resp_valid", 64'(m32.resp_valid), 64'd0);
        check_val("rst resp_out",   64'(m32.resp_out),   64'd0);
        check_val("rst64 resp_out", m64.resp_out,        64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed XLEN=32 vectors
        issue(0, MD_OP_MUL, 1, 1, MD_OUT_LO, 64'hFFFF_FFFF, 64'h5, 1, "mul_lo");
        issue(0, MD_OP_MUL, 1, 1, MD_OUT_HI, 64'h8000_0000, 64'hFFFF_FFFF, 1, "mulh");
        issue(0, MD_OP_MUL, 1, 0, MD_OUT_HI, 64'h8000_0000, 64'hFFFF_FFFF, 1, "mulhsu");
        issue(0, MD_OP_MUL, 0, 0, MD_OUT_HI, 64'h8000_0000, 64'hFFFF_FFFF, 1, "mulhu");
        issue(0, MD_OP_DIV, 1, 1, 0, 64'hFFFF_FFF9, 64'h2, 1, "div -7/2");
        issue(0, MD_OP_REM, 1, 1, 0, 64'hFFFF_FFF9, 64'h2, 1, "rem -7/2");
        issue(0, MD_OP_DIV, 1, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 1, "div ovf");
        issue(0, MD_OP_REM, 1, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 1, "rem ovf");
        issue(0, MD_OP_DIV, 1, 1, 0, 64'h1234, 64'h0, 1, "div by 0");
        issue(0, MD_OP_DIV, 0, 0, 0, 64'h1234, 64'h0, 1, "divu by 0");
        issue(0, MD_OP_REM, 0, 0, 0, 64'h1234, 64'h0, 1, "remu by 0");
        issue(0, MD_OP_DIV, 1, 1, 0, 64'hFFFF_FFFB, 64'h0, 1, "div -5/0");
        issue(0, MD_OP_REM, 1, 1, 0, 64'hFFFF_FFFB, 64'h0, 1, "rem -5/0");
        issue(0, MD_OP_DIV, 0, 0, 0, 64'hFFFF_FFFF, 64'h3, 1, "divu");
        issue(0, 2'd3,      0, 0, 0, 64'd7, 64'd6, 1, "op3 as mul");
        for (int i = 0; i < 12; i++)
            issue(0, 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 1'($urandom),
                  {32'd0, $urandom}, {32'd0, $urandom}, 1, "rand32");
        drain();

        // Response held off by resp_ready low
        @(posedge clk); #1 m32.resp_ready = 1'b0;
        issue(0, MD_OP_MUL, 0, 0, MD_OUT_LO, 64'd3, 64'd4, 1, "hold mul");
        g = 0;
        while (!m32.resp_valid && g < 100) begin @(negedge clk); g++; end
        check_val("hold valid seen", 64'(m32.resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("hold resp_valid", 64'(m32.resp_valid), 64'd1);
            check_val("hold resp_out",   64'(m32.resp_out),   64'd12);
            check_val("hold req_ready",  64'(m32.req_ready),  64'd0);
        end
        @(posedge clk); #1 m32.resp_ready = 1'b1;
        @(negedge clk);
        check_val("hs req_ready", 64'(m32.req_ready), 64'd0);
        @(negedge clk);
        check_val("post hs resp_valid", 64'(m32.resp_valid), 64'd0);
        check_val("post hs req_ready",  64'(m32.req_ready),  64'd1);

        // Kill in the 10th compute cycle
        issue(0, MD_OP_MUL, 0, 0, MD_OUT_LO, 64'd9, 64'd9, 0, "killed");
        repeat (10) @(posedge clk);
        #1 m32.kill = 1'b1;
        @(posedge clk);
        #1 m32.kill = 1'b0;
        @(negedge clk);
        check_val("kill resp_valid", 64'(m32.resp_valid), 64'd0);
        check_val("kill req_ready",  64'(m32.req_ready),  64'd1);
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (m32.resp_valid) seen = 1'b1; end
        check_val("kill no resp", 64'(seen), 64'd0);
        issue(0, MD_OP_DIV, 1, 1, 0, 64'hFFFF_FF9C, 64'd7, 1, "after kill");
        drain();

        // Asynchronous reset in the middle of a computation
        issue(0, MD_OP_DIV, 0, 0, 0, 64'd1000, 64'd3, 0, "reset op");
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_val("async rst req_ready",  64'(m32.req_ready),  64'd1);
        check_val("async rst resp_valid", 64'(m32.resp_valid), 64'd0);
        check_val("async rst resp_out",   64'(m32.resp_out),   64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (m32.resp_valid) seen = 1'b1; end
        check_val("reset no resp", 64'(seen), 64'd0);

        // XLEN=64 sweep over all op/sign/out_sel combinations
        for (int c = 0; c < 8; c++)
            for (int j = 0; j < 7; j++)
                issue(1, cop[c], cs1[c], cs2[c], csel[c],
                      pick64((j + c) % 6), pick64((2 * j + 1) % 6), 1, $sformatf("x64 c%0d j%0d", c, j));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_mul_div_iter.md
Name: vscale_mul_div_iter

Overview:
- Parametrised, iterative, radix-2 multiply/divide unit for the vscale pipeline, implementing RV32M/RV64M MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the ALU in the execute stage. The pipeline control stalls on req_ready/resp_valid.
- Adds the following over the first-generation stub:
  - XLEN generalisation
  - valid/ready request and response handshakes
  - abort (kill)
  - RISC-V-defined divide-by-zero and overflow results

Parameters:
XLEN, 32, operand/result width; must be a power of 2 and at least 8
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not to be overridden

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in S_IDLE
req_op  in  2  MD_OP_MUL=0, MD_OP_DIV=1, MD_OP_REM=2; value 3 is reserved and treated as MUL
req_in_1_signed  in  1  operand 1 is two's complement
req_in_2_signed  in  1  operand 2 is two's complement
req_out_sel  in  1  MD_OUT_LO=0, MD_OUT_HI=1 (MUL only; ignored for DIV/REM)
req_in_1  in  XLEN  multiplicand / dividend
req_in_2  in  XLEN  multiplier / divisor
kill  in  1  abort any in-flight operation
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts the result
resp_out  out  XLEN  result

Behaviour:
- Reset: state=S_IDLE, counter=0, all datapath registers=0. Outputs: req_ready=1, resp_valid=0, resp_out=0.
- Request handshake: a request is accepted on a cycle where req_valid && req_ready. All req_* inputs are captured on that edge and are don't-care afterwards.
- State machine: S_IDLE -> S_SETUP -> S_COMPUTE -> S_FINISH -> S_DONE -> S_IDLE.
- S_SETUP (1 cycle):
  - Take the absolute value of each operand whose signed flag is set and whose MSB is 1.
  - Record neg_out:
    - MUL: sign1 XOR sign2.
    - DIV: sign1 XOR sign2, forced to 0 when divisor==0.
    - REM: sign1.
  - Load counter=XLEN.
- S_COMPUTE (XLEN cycles, counter decrements to 0):
  - MUL: shift-add on a 2*XLEN accumulator using unsigned magnitudes.
  - DIV/REM: restoring division, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
- S_FINISH (1 cycle):
  - Negate the full 2*XLEN product or the quotient if neg_out; negate the remainder if REM and neg_out.
  - Select the output: MUL lo or hi XLEN bits, per out_sel; DIV quotient; REM remainder. Register it into resp_out.
- S_DONE: resp_valid=1 and resp_out held stable until resp_ready. On resp_valid && resp_ready, go to S_IDLE; resp_valid drops the next cycle.
- Latency: accept edge to first resp_valid cycle = XLEN+2 cycles, fixed and data-independent. There is no early-out.
- Throughput: one operation per XLEN+3 cycles minimum, since req_ready is low from S_SETUP through S_DONE.
- No back-to-back accept: req_ready is low in S_DONE, even on the cycle the response handshake fires.
- Divide by zero: quotient = all ones, remainder = dividend, for signed and unsigned. The restoring algorithm produces these naturally provided neg_out is forced to 0 for DIV.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0. Handled by unsigned magnitudes with no special case; must be verified.
- kill:
  - Highest priority. In any state other than S_IDLE, kill forces state=S_IDLE and resp_valid=0 at the next edge.
  - In S_IDLE, kill blocks acceptance that cycle, since req_ready is qualified by !kill.
  - resp_out keeps its last value.
- Reset asserted mid-operation: immediate return to the reset values. No response is produced.
- resp_out is registered and changes only in S_FINISH.

Decomposition:
- Shared header (extend vscale_ctrl_constants.vh, or add vscale_md_constants.vh):
  - MD_OP_WIDTH=2, MD_OP_MUL/DIV/REM
  - MD_OUT_LO/HI
  - state encodings S_IDLE..S_DONE, 3-bit
- One sub-module, vscale_md_negate: a parametrised conditional two's-complement negator (width param, in, en, out). It is instantiated for the operands in S_SETUP and for the result in S_FINISH.
- The FSM, counter and shift/subtract datapath stay in the top module.

Test Plan:
- MUL, signed/signed, lo: 0xFFFFFFFF * 0x00000005 -> resp_out=0xFFFFFFFB. resp_valid first asserts exactly 34 cycles after the accept edge.
- MULH/MULHSU/MULHU, hi, on 0x80000000 * 0xFFFFFFFF:
  - signed/signed -> 0x00000000
  - signed/unsigned -> 0x80000000
  - unsigned/unsigned -> 0x7FFFFFFF
- DIV/REM, signed: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Overflow 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero: DIV 0x00001234 / 0 -> 0xFFFFFFFF for signed and unsigned. REMU 0x00001234 / 0 -> 0x00001234. Signed DIV -5 / 0 -> 0xFFFFFFFF.
- Handshake and abort:
  - resp_ready held low 5 cycles: resp_valid and resp_out stay stable, req_ready stays low.
  - kill in cycle 10 of S_COMPUTE: no resp_valid, req_ready=1 on the next cycle, and a new request completes correctly.
  - reset_n pulsed mid-S_COMPUTE: outputs return to their reset values asynchronously.
- Parametric run at XLEN=64 with a randomised golden-model compare over all 8 op/sign/out_sel combinations, including 0, 1, -1, the min value and the max value. Latency = 66 cycles.
